// File: rtl/alu_mc_pkg.sv
// Shared ALU control codes and FSM encodings for the EX-stage ALU.
package alu_mc_pkg;

   localparam logic [2:0] ALUCTRL_AND = 3'b000;
   localparam logic [2:0] ALUCTRL_OR  = 3'b001;
   localparam logic [2:0] ALUCTRL_ADD = 3'b010;
   localparam logic [2:0] ALUCTRL_SUB = 3'b110;
   localparam logic [2:0] ALUCTRL_MUL = 3'b100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// EX-stage ALU request/response bundle.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic             ready_o;
   logic             stall_o;
   logic             done_o;
   logic [WIDTH-1:0] data_o;
   logic             zero_o;

   modport master (
      output valid_i, ALUCtrl_i, data1_i, data2_i,
      input  ready_o, stall_o, done_o, data_o, zero_o
   );

   modport slave (
      input  valid_i, ALUCtrl_i, data1_i, data2_i,
      output ready_o, stall_o, done_o, data_o, zero_o
   );
endinterface

// File: rtl/alu_mc_mul_seq.sv
// Iterative shift-add multiplier; one multiplier bit per clock.
module alu_mul_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             last_o,
   output logic [WIDTH-1:0] product_o
);
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;

   assign acc_d     = mplier_q[0] ? acc_q + mcand_q : acc_q;
   assign last_o    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign busy_o    = busy_q;
   // Final-iteration sum, so the product lands on the same edge as last_o.
   assign product_o = acc_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (last_o)
            busy_q <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith, iterative mul.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic   clk_i,
   input logic   rst_i,
   alu_mc_if.slave bus
);
   state_e           state_q;
   logic [WIDTH-1:0] data_q;
   logic             zero_q;
   logic             done_q;
   logic [WIDTH-1:0] alu_d;
   logic [WIDTH-1:0] product;
   logic             mul_busy;
   logic             mul_last;
   logic             accept;
   logic             start;

   assign accept = (state_q == ST_IDLE) && bus.valid_i;
   assign start  = accept && (bus.ALUCtrl_i == ALUCTRL_MUL);

   always_comb begin
      alu_d = bus.data1_i + bus.data2_i;
      unique case (bus.ALUCtrl_i)
         ALUCTRL_AND: alu_d = bus.data1_i & bus.data2_i;
         ALUCTRL_OR:  alu_d = bus.data1_i | bus.data2_i;
         ALUCTRL_SUB: alu_d = bus.data1_i - bus.data2_i;
         default:     alu_d = bus.data1_i + bus.data2_i;
      endcase
   end

   alu_mul_seq #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (start),
      .a_i       (bus.data1_i),
      .b_i       (bus.data2_i),
      .busy_o    (mul_busy),
      .last_o    (mul_last),
      .product_o (product)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         zero_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_MUL;
               end else if (accept) begin
                  data_q <= alu_d;
                  zero_q <= (alu_d == '0);
                  done_q <= 1'b1;
               end
            end
            ST_MUL: begin
               if (mul_last) begin
                  data_q  <= product;
                  zero_q  <= (product == '0);
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.ready_o = (state_q == ST_IDLE);
   assign bus.stall_o = mul_busy || start;
   assign bus.done_o  = done_q;
   assign bus.data_o  = data_q;
   assign bus.zero_o  = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed ops, mul latency, reset abort.
module tb_alu_mc;
   import alu_mc_pkg::*;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_fail;
   exp_t sb[$];

   alu_mc_if #(.WIDTH(32)) bus();

   alu_mc #(.WIDTH(32), .CNT_W(6)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops an expectation on every done_o pulse.
   always @(negedge clk) begin
      if (!rst && bus.done_o === 1'b1) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got data %h at cycle %0d expected no done",
                     bus.data_o, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("data_o", bus.data_o, e.data);
            check("zero_o", {31'd0, bus.zero_o}, {31'd0, e.data == 32'd0});
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic op1(input logic [2:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      exp_t e;
      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = c;
      bus.data1_i   = a;
      bus.data2_i   = b;
      e.data = exp;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      #1;
      check("stall_single", {31'd0, bus.stall_o}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic mul(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
      exp_t e;
      int   good;
      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = ALUCTRL_MUL;
      bus.data1_i   = a;
      bus.data2_i   = b;
      e.data = exp;
      e.cyc  = cyc + 33;
      sb.push_back(e);
      #1;
      check("stall_accept", {31'd0, bus.stall_o}, 32'd1);
      @(posedge clk);
      #1;
      bus.valid_i   = 1'b0;
      bus.ALUCtrl_i = ALUCTRL_ADD;
      good = 0;
      for (int i = 0; i < 32; i++) begin
         if (bus.stall_o === 1'b1 && bus.ready_o === 1'b0)
            good++;
         bus.data1_i = $urandom;
         bus.data2_i = $urandom;
         @(posedge clk);
         #1;
      end
      check("stall_cycles", good, 32);
      check("stall_done_cycle", {31'd0, bus.stall_o}, 32'd0);
      check("ready_done_cycle", {31'd0, bus.ready_o}, 32'd1);
   endtask

   task automatic idle();
      bus.valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() > 0; i++)
         @(posedge clk);
      #1;
      check("drain_timeout", sb.size(), 0);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_data"},  bus.data_o, 32'd0);
      check({tag, "_zero"},  {31'd0, bus.zero_o}, 32'd1);
      check({tag, "_done"},  {31'd0, bus.done_o}, 32'd0);
      check({tag, "_ready"}, {31'd0, bus.ready_o}, 32'd1);
      check({tag, "_stall"}, {31'd0, bus.stall_o}, 32'd0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      bus.valid_i   = 1'b0;
      bus.ALUCtrl_i = ALUCTRL_ADD;
      bus.data1_i   = '0;
      bus.data2_i   = '0;
      #2;
      check_reset_outs("rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outs("idle");

      op1(ALUCTRL_ADD, 32'd7, 32'd5, 32'd12);
      op1(ALUCTRL_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
      op1(ALUCTRL_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
      op1(ALUCTRL_OR,  32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF);
      op1(3'b111, 32'd3, 32'd4, 32'd7);
      op1(ALUCTRL_SUB, 32'd9, 32'd9, 32'd0);
      op1(ALUCTRL_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
      idle();
      drain();

      mul(32'd6, 32'd7, 32'd42);
      op1(ALUCTRL_ADD, 32'd1, 32'd2, 32'd3);
      idle();
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("data_hold", bus.data_o, 32'd3);

      mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
      idle();
      drain();

      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = ALUCTRL_MUL;
      bus.data1_i   = 32'd6;
      bus.data2_i   = 32'd7;
      @(posedge clk);
      #1;
      idle();
      repeat (10) @(posedge clk);
      #1;
      check("mid_mul_stall", {31'd0, bus.stall_o}, 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outs("abort");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      op1(ALUCTRL_ADD, 32'd2, 32'd2, 32'd4);
      idle();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
